// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared defaults and types for the mac array sequencer
package mac_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 20;
  localparam int K_WIDTH_DEF    = 8;
  localparam int MAC_LAT_DEF    = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4
  } seq_state_e;

  typedef logic [1:0] res_idx_t;

  localparam res_idx_t RES_IDX_LAST = 2'd3;

endpackage

// File: rtl/mac_seq_drain.sv
// rtl/mac_seq_drain.sv - accumulator snapshot and four-beat valid/ready result serialiser
module mac_seq_drain
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] acc_00,
  input  logic [ACC_WIDTH-1:0] acc_01,
  input  logic [ACC_WIDTH-1:0] acc_10,
  input  logic [ACC_WIDTH-1:0] acc_11,
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [ACC_WIDTH-1:0] res_data,
  output res_idx_t             res_idx,
  output logic                 res_last,
  output logic                 final_hs
);

  logic [ACC_WIDTH-1:0] snap [4];
  res_idx_t             idx_nxt;
  logic                 beat_hs;

  assign beat_hs  = res_valid && res_ready;
  assign final_hs = beat_hs && res_last;
  assign idx_nxt  = res_idx + 2'd1;

  // Capture all four accumulators in one edge so later array activity cannot disturb the drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap[0] <= '0;
      snap[1] <= '0;
      snap[2] <= '0;
      snap[3] <= '0;
    end else if (load) begin
      snap[0] <= acc_00;
      snap[1] <= acc_01;
      snap[2] <= acc_10;
      snap[3] <= acc_11;
    end
  end

  // Present one result per handshake; data/idx/last only move on a completed beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_last  <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_data  <= acc_00;
      res_idx   <= '0;
      res_last  <= 1'b0;
    end else if (beat_hs) begin
      if (res_last) begin
        res_valid <= 1'b0;
        res_data  <= '0;
        res_idx   <= '0;
        res_last  <= 1'b0;
      end else begin
        res_data  <= snap[idx_nxt];
        res_idx   <= idx_nxt;
        res_last  <= (idx_nxt == RES_IDX_LAST);
      end
    end
  end

endmodule

// File: rtl/mac_array_sequencer.sv
// rtl/mac_array_sequencer.sv - job sequencer for mac_array_2x2; optional stall counter under MAC_SEQ_PERF_EN
module mac_array_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int K_WIDTH    = K_WIDTH_DEF,
  parameter int MAC_LAT    = MAC_LAT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a_row0,
  input  logic [DATA_WIDTH-1:0] in_a_row1,
  input  logic [DATA_WIDTH-1:0] in_b_col0,
  input  logic [DATA_WIDTH-1:0] in_b_col1,
  output logic                  mac_enable,
  output logic                  mac_clear,
  output logic [DATA_WIDTH-1:0] a_00,
  output logic [DATA_WIDTH-1:0] a_01,
  output logic [DATA_WIDTH-1:0] a_10,
  output logic [DATA_WIDTH-1:0] a_11,
  output logic [DATA_WIDTH-1:0] b_00,
  output logic [DATA_WIDTH-1:0] b_01,
  output logic [DATA_WIDTH-1:0] b_10,
  output logic [DATA_WIDTH-1:0] b_11,
  input  logic [ACC_WIDTH-1:0]  acc_00,
  input  logic [ACC_WIDTH-1:0]  acc_01,
  input  logic [ACC_WIDTH-1:0]  acc_10,
  input  logic [ACC_WIDTH-1:0]  acc_11,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic [1:0]            res_idx,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           perf_stall_cnt
);

  seq_state_e           state, next_state;
  logic [K_WIDTH-1:0]   k_lat;
  logic [K_WIDTH-1:0]   beat_cnt;
  logic [7:0]           wait_cnt;
  logic                 accept;
  logic                 last_beat;
  logic                 wait_done;
  logic                 final_hs;
  res_idx_t             drain_idx;

  assign accept    = in_valid && in_ready;
  assign last_beat = ((beat_cnt + K_WIDTH'(1)) == k_lat);
  // The final beat's mac_enable is live during the first WAIT cycle, so the snapshot is
  // taken MAC_LAT cycles after that, once the array has folded the beat in.
  assign wait_done = (state == S_WAIT) && (wait_cnt == 8'(MAC_LAT));
  assign res_idx   = drain_idx;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decision for the job flow
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_CLEAR;
      S_CLEAR:  next_state = (k_lat == '0) ? S_WAIT : S_STREAM;
      S_STREAM: if (accept && last_beat) next_state = S_WAIT;
      S_WAIT:   if (wait_done) next_state = S_DRAIN;
      S_DRAIN:  if (final_hs) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Registered control outputs and job counters, all derived from the upcoming state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b0;
      mac_clear <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      k_lat     <= '0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      in_ready  <= (next_state == S_STREAM);
      mac_clear <= (next_state == S_CLEAR);
      busy      <= (next_state != S_IDLE);
      done      <= final_hs;
      if (state == S_IDLE && start) begin
        k_lat    <= k_len;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + K_WIDTH'(1);
      end
      if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
      else                 wait_cnt <= '0;
    end
  end

  // Operand fan-out to the array; operands hold across bubbles while mac_enable drops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mac_enable <= 1'b0;
      a_00 <= '0; a_01 <= '0; a_10 <= '0; a_11 <= '0;
      b_00 <= '0; b_01 <= '0; b_10 <= '0; b_11 <= '0;
    end else begin
      mac_enable <= accept;
      if (accept) begin
        a_00 <= in_a_row0; a_01 <= in_a_row0;
        a_10 <= in_a_row1; a_11 <= in_a_row1;
        b_00 <= in_b_col0; b_10 <= in_b_col0;
        b_01 <= in_b_col1; b_11 <= in_b_col1;
      end
    end
  end

  mac_seq_drain #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_drain (
    .clock     (clock),
    .reset     (reset),
    .load      (wait_done),
    .acc_00    (acc_00),
    .acc_01    (acc_01),
    .acc_10    (acc_10),
    .acc_11    (acc_11),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_idx   (drain_idx),
    .res_last  (res_last),
    .final_hs  (final_hs)
  );

`ifdef MAC_SEQ_PERF_EN
  logic stall_cycle;

  assign stall_cycle = ((state == S_STREAM) && !in_valid) ||
                       ((state == S_DRAIN) && res_valid && !res_ready);

  // Saturating stall counter, restarted when a new job is accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      perf_stall_cnt <= '0;
    end else if (stall_cycle && perf_stall_cnt != 16'hFFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb/tb_mac_array_sequencer.sv - self-checking bench for mac_array_sequencer with a behavioural 2x2 array
module tb_mac_array_sequencer;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int KW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a_row0 = '0, in_a_row1 = '0, in_b_col0 = '0, in_b_col1 = '0;
  logic          mac_enable, mac_clear;
  logic [DW-1:0] a_00, a_01, a_10, a_11, b_00, b_01, b_10, b_11;
  logic [AW-1:0] acc_00, acc_01, acc_10, acc_11;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [AW-1:0] res_data;
  logic [1:0]    res_idx;
  logic          res_last, busy, done;
  logic [15:0]   perf_stall_cnt;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mac_array_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_row0(in_a_row0), .in_a_row1(in_a_row1), .in_b_col0(in_b_col0), .in_b_col1(in_b_col1),
    .mac_enable(mac_enable), .mac_clear(mac_clear),
    .a_00(a_00), .a_01(a_01), .a_10(a_10), .a_11(a_11),
    .b_00(b_00), .b_01(b_01), .b_10(b_10), .b_11(b_11),
    .acc_00(acc_00), .acc_01(acc_01), .acc_10(acc_10), .acc_11(acc_11),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .res_last(res_last), .busy(busy), .done(done), .perf_stall_cnt(perf_stall_cnt)
  );

  // Behavioural 2x2 MAC array: clear wins, otherwise accumulate one product per enabled cycle
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_00 <= '0; acc_01 <= '0; acc_10 <= '0; acc_11 <= '0;
    end else if (mac_clear) begin
      acc_00 <= '0; acc_01 <= '0; acc_10 <= '0; acc_11 <= '0;
    end else if (mac_enable) begin
      acc_00 <= acc_00 + AW'(a_00) * AW'(b_00);
      acc_01 <= acc_01 + AW'(a_01) * AW'(b_01);
      acc_10 <= acc_10 + AW'(a_10) * AW'(b_10);
      acc_11 <= acc_11 + AW'(a_11) * AW'(b_11);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Model state shared between stimulus and the compare process
  logic [DW-1:0] bA0 [16], bA1 [16], bB0 [16], bB1 [16];
  logic [AW-1:0] exp_data_q [$];
  int            exp_idx_q [$];
  logic [AW-1:0] got_q [$];
  int            job_k = 0;
  int            beats_taken = 0;
  int            clear_seen = 0;
  int            stall_seen = 0;
  int            stall_idx = -1;
  int            stall_left = 0;

  // Result-side backpressure: hold res_ready low for stall_left cycles once stall_idx appears
  always @(posedge clock) begin
    #1;
    if (stall_left > 0 && res_valid && int'(res_idx) == stall_idx) begin
      res_ready = 1'b0;
      stall_left--;
    end else begin
      res_ready = 1'b1;
    end
  end

  // Compare process: every cycle, outputs against the job-level model
  logic          prev_accept = 1'b0, prev_final = 1'b0, held_v = 1'b0;
  logic [AW-1:0] held_data;
  logic [1:0]    held_idx;
  logic [DW-1:0] pa0, pa1, pb0, pb1;
  always @(negedge clock) begin
    if (reset) begin
      prev_accept = 1'b0;
      prev_final  = 1'b0;
      held_v      = 1'b0;
    end else begin
      check("done_pulse", done, prev_final);
      check("perf_stall_cnt", perf_stall_cnt, 0);
      check("mac_enable", mac_enable, prev_accept);
      if (prev_accept) begin
        check("a_00", a_00, pa0); check("a_01", a_01, pa0);
        check("a_10", a_10, pa1); check("a_11", a_11, pa1);
        check("b_00", b_00, pb0); check("b_10", b_10, pb0);
        check("b_01", b_01, pb1); check("b_11", b_11, pb1);
      end
      if (mac_clear) begin
        clear_seen++;
        check("clear_before_stream", beats_taken, 0);
      end
      if (held_v) begin
        check("held_valid", res_valid, 1);
        check("held_data", res_data, held_data);
        check("held_idx", res_idx, held_idx);
      end
      held_v    = res_valid && !res_ready;
      held_data = res_data;
      held_idx  = res_idx;
      if (held_v) stall_seen++;
      prev_final = res_valid && res_ready && res_last;
      if (res_valid && res_ready) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          logic [AW-1:0] ed;
          int ei;
          ed = exp_data_q.pop_front();
          ei = exp_idx_q.pop_front();
          check("res_data", res_data, ed);
          check("res_idx", res_idx, ei);
          check("res_last", res_last, (ei == 3));
        end
        got_q.push_back(res_data);
      end
      prev_accept = in_valid && in_ready;
      if (prev_accept) begin
        pa0 = in_a_row0; pa1 = in_a_row1; pb0 = in_b_col0; pb1 = in_b_col1;
        beats_taken++;
        check("no_over_accept", (beats_taken <= job_k), 1);
        check("busy_while_streaming", busy, 1);
      end
    end
  end

  task automatic set_beat(input int i, input int a0, input int a1, input int b0, input int b1);
    bA0[i] = DW'(a0); bA1[i] = DW'(a1); bB0[i] = DW'(b0); bB1[i] = DW'(b1);
  endtask

  task automatic drive_beat(input int i, output logic ok);
    int   tmo;
    logic hit;
    in_valid = 1'b1;
    in_a_row0 = bA0[i]; in_a_row1 = bA1[i]; in_b_col0 = bB0[i]; in_b_col1 = bB1[i];
    hit = 1'b0;
    tmo = 0;
    while (!hit && tmo < 100) begin
      @(negedge clock);
      hit = in_ready;
      tmo++;
    end
    ok = hit;
    if (!hit) begin
      check("beat_accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
  endtask

  // One full job: model the 2x2 product, run the DUT, wait for the drain to finish
  task automatic run_job(input int k, input int gap, input int ign_start);
    logic [AW-1:0] c00, c01, c10, c11;
    int   tmo;
    logic ok;
    c00 = '0; c01 = '0; c10 = '0; c11 = '0;
    for (int i = 0; i < k; i++) begin
      c00 = c00 + AW'(bA0[i]) * AW'(bB0[i]);
      c01 = c01 + AW'(bA0[i]) * AW'(bB1[i]);
      c10 = c10 + AW'(bA1[i]) * AW'(bB0[i]);
      c11 = c11 + AW'(bA1[i]) * AW'(bB1[i]);
    end
    exp_data_q.push_back(c00); exp_idx_q.push_back(0);
    exp_data_q.push_back(c01); exp_idx_q.push_back(1);
    exp_data_q.push_back(c10); exp_idx_q.push_back(2);
    exp_data_q.push_back(c11); exp_idx_q.push_back(3);
    job_k = k; beats_taken = 0; clear_seen = 0; stall_seen = 0;
    got_q.delete();
    @(posedge clock); #1;
    start = 1'b1; k_len = KW'(k);
    @(posedge clock); #1;
    start = 1'b0; k_len = 8'hAA;
    for (int i = 0; i < k; i++) begin
      drive_beat(i, ok);
      if (!ok) break;
      if (ign_start != 0 && i == 0) begin
        start = 1'b1; k_len = 8'd5;
        @(posedge clock); #1;
        start = 1'b0;
      end
      repeat (gap) begin @(posedge clock); #1; end
    end
    tmo = 0;
    while ((busy || exp_data_q.size() != 0) && tmo < 400) begin
      @(negedge clock);
      tmo++;
    end
    check("job_complete_in_time", (tmo < 400), 1);
    @(posedge clock); #1;
    check("one_clear_per_job", clear_seen, 1);
    check("beats_per_job", beats_taken, k);
  endtask

  task automatic check_lits(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_count"}, got_q.size(), 4);
    if (got_q.size() == 4) begin
      check({tag, "_r0"}, got_q[0], e0);
      check({tag, "_r1"}, got_q[1], e1);
      check({tag, "_r2"}, got_q[2], e2);
      check({tag, "_r3"}, got_q[3], e3);
    end
  endtask

  task automatic load_test2_beats();
    set_beat(0, 2, 6, 3, 5);
    set_beat(1, 1, 5, 2, 4);
  endtask

  initial begin
    logic ok;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mac_clear", mac_clear, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_a_00", a_00, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: single beat
    set_beat(0, 3, 0, 4, 0);
    run_job(1, 0, 0);
    check_lits("t1", 12, 0, 0, 0);

    // 2: two beats back to back
    load_test2_beats();
    run_job(2, 0, 0);
    check_lits("t2", 8, 14, 28, 50);

    // 3: two-cycle input bubbles
    run_job(2, 2, 0);
    check_lits("t3", 8, 14, 28, 50);

    // 4: result backpressure at idx 1
    stall_idx = 1; stall_left = 3;
    run_job(2, 0, 0);
    check_lits("t4", 8, 14, 28, 50);
    check("t4_stall_cycles", stall_seen, 3);
    stall_idx = -1;

    // 5: full-scale operands, then an empty job
    for (int i = 0; i < 16; i++) set_beat(i, 255, 255, 255, 255);
    run_job(16, 0, 0);
    check_lits("t5", 1040400, 1040400, 1040400, 1040400);
    run_job(0, 0, 0);
    check_lits("t5z", 0, 0, 0, 0);

    // 6: asynchronous reset mid-stream, then a job with a stray start while busy
    load_test2_beats();
    job_k = 2; beats_taken = 0;
    @(posedge clock); #1;
    start = 1'b1; k_len = 8'd2;
    @(posedge clock); #1;
    start = 1'b0;
    drive_beat(0, ok);
    #1;
    check("t6_pre_rst_a_00", a_00, 2);
    check("t6_pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mac_enable", mac_enable, 0);
    check("t6_rst_a_00", a_00, 0);
    check("t6_rst_b_11", b_11, 0);
    check("t6_rst_res_valid", res_valid, 0);
    check("t6_rst_done", done, 0);
    exp_data_q.delete(); exp_idx_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    run_job(2, 1, 1);
    check_lits("t6", 8, 14, 28, 50);
    repeat (4) @(posedge clock);
    #1;
    check("t6_idle_after", busy, 0);
    check("t6_no_extra_result", res_valid, 0);
    set_beat(0, 3, 0, 4, 0);
    run_job(1, 0, 0);
    check_lits("t6b", 12, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
